// File: rtl/seq_alu.sv
// Registered, handshaked ALU: single-cycle arith/logic/shift ops plus iterative
// MUL and unsigned DIV/REM that take a fixed WIDTH iteration cycles.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alufn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [5:0] {
    OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000010, OP_DIVU = 6'b000011,
    OP_AND  = 6'b000100, OP_OR  = 6'b000101, OP_XOR = 6'b000110, OP_REMU = 6'b000111,
    OP_SLL  = 6'b001000, OP_SRL = 6'b001001, OP_SRA = 6'b001010, OP_SLT  = 6'b001011
  } op_e;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  localparam int MSB = WIDTH - 1;
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, overflow_q, illegal_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic             iter_mul_q, iter_rem_q;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, sc_result;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, sc_illegal, start_iter;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sc_result  = '0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    start_iter = 1'b0;
    case (alufn)
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_MUL, OP_DIVU, OP_REMU: start_iter = 1'b1;
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_SLL: sc_result = a << shamt;
      OP_SRL: sc_result = a >> shamt;
      OP_SRA: sc_result = $unsigned($signed(a) >>> shamt);
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring subtract-shift for DIVU/REMU.
  // x_q holds the multiplicand (MUL) or the dividend shifting into the quotient (DIV).
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff, step_acc, step_x, step_y, iter_result;
  logic             can_sub;

  assign rem_shift = {acc_q, x_q[MSB]};
  assign can_sub   = rem_shift >= {1'b0, y_q};
  assign rem_diff  = rem_shift[WIDTH-1:0] - y_q;

  always_comb begin
    step_acc = acc_q;
    step_x   = x_q;
    step_y   = y_q;
    if (iter_mul_q) begin
      step_acc = acc_q + (y_q[0] ? x_q : '0);
      step_x   = x_q << 1;
      step_y   = y_q >> 1;
    end else begin
      step_acc = can_sub ? rem_diff : rem_shift[WIDTH-1:0];
      step_x   = {x_q[MSB-1:0], can_sub};
    end
    iter_result = (iter_mul_q || iter_rem_q) ? step_acc : step_x;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = start_iter ? ITER : DONE;
      ITER:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      iter_mul_q <= 1'b0;
      iter_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (start_iter) begin
            acc_q      <= '0;
            x_q        <= a;
            y_q        <= b;
            cnt_q      <= CNT_INIT;
            iter_mul_q <= (alufn == OP_MUL);
            iter_rem_q <= (alufn == OP_REMU);
          end else begin
            result_q   <= sc_result;
            zero_q     <= !sc_illegal && (sc_result == '0);
            overflow_q <= sc_ovf;
            illegal_q  <= sc_illegal;
          end
        end
        ITER: begin
          acc_q <= step_acc;
          x_q   <= step_x;
          y_q   <= step_y;
          cnt_q <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            result_q   <= iter_result;
            zero_q     <= (iter_result == '0);
            // Divisor never shifts during DIV/REM, so y_q still holds b here.
            overflow_q <= !iter_mul_q && (y_q == '0);
            illegal_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at WIDTH=32 and WIDTH=8: table of hand-computed
// results plus sequences for backpressure, busy-during-ITER and mid-operation reset.
module tb_seq_alu;

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_MUL = 6'h02, OP_DIVU = 6'h03;
  localparam logic [5:0] OP_AND = 6'h04, OP_OR  = 6'h05, OP_XOR = 6'h06, OP_REMU = 6'h07;
  localparam logic [5:0] OP_SLL = 6'h08, OP_SRL = 6'h09, OP_SRA = 6'h0A, OP_SLT  = 6'h0B;

  typedef struct {
    bit          w8;
    logic [5:0]  op;
    logic [31:0] a, b, res;
    logic        z, o, il;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, out_ready;
  logic        in_valid, in_ready, out_valid, zero, overflow, illegal;
  logic [5:0]  alufn;
  logic [31:0] a, b, result;
  logic        in_valid8, in_ready8, out_valid8, zero8, overflow8, illegal8;
  logic [5:0]  alufn8;
  logic [7:0]  a8, b8, result8;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alufn(alufn), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alufn(alufn8), .out_valid(out_valid8), .out_ready(out_ready),
    .result(result8), .zero(zero8), .overflow(overflow8), .illegal(illegal8)
  );

  logic        use8;
  logic        cur_in_ready, cur_out_valid, cur_zero, cur_ovf, cur_ill;
  logic [31:0] cur_result;
  assign cur_in_ready  = use8 ? in_ready8  : in_ready;
  assign cur_out_valid = use8 ? out_valid8 : out_valid;
  assign cur_zero      = use8 ? zero8      : zero;
  assign cur_ovf       = use8 ? overflow8  : overflow;
  assign cur_ill       = use8 ? illegal8   : illegal;
  assign cur_result    = use8 ? {24'h0, result8} : result;

  int   n_vec = 0;
  int   n_miss = 0;
  int   lat, bad;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit w8, input logic [5:0] op, input logic [31:0] va, vb, res,
                     input logic z, o, il, input int l);
    vec_t v;
    v.w8 = w8; v.op = op; v.a = va; v.b = vb; v.res = res;
    v.z = z; v.o = o; v.il = il; v.lat = l;
    vecs.push_back(v);
  endtask

  // Presents one op, leaves the bench at the negedge after the accepting edge.
  task automatic start_op(input logic [5:0] op, input logic [31:0] va, vb);
    @(negedge clk);
    check("in_ready before accept", {31'h0, cur_in_ready}, 32'h1);
    if (use8) begin
      alufn8 = op; a8 = va[7:0]; b8 = vb[7:0]; in_valid8 = 1'b1;
    end else begin
      alufn = op; a = va; b = vb; in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
  endtask

  // Latency counts rising edges from the accepting edge to the one raising out_valid.
  task automatic wait_done(output int l);
    l = 1;
    while (!cur_out_valid && l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, {31'h0, cur_out_valid}, 32'h0);
    check({tag, " in_ready after take"},  {31'h0, cur_in_ready},  32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; use8 = 1'b0;
    in_valid = 1'b0; alufn = '0; a = '0; b = '0;
    in_valid8 = 1'b0; alufn8 = '0; a8 = '0; b8 = '0;

    //  w8 op        a             b             result        z     o     il    lat
    add(0, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
    add(0, OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    add(0, OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1);
    add(0, OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    add(0, OP_MUL,  32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33);
    add(0, OP_MUL,  32'h00000000, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 33);
    add(0, OP_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 33);
    add(0, OP_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 33);
    add(0, OP_DIVU, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 33);
    add(0, OP_REMU, 32'd9,        32'd0,        32'd9,        1'b0, 1'b1, 1'b0, 33);
    add(0, OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0, 33);
    add(0, OP_REMU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0, 1'b0, 1'b0, 33);
    add(0, OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_OR,   32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_SLL,  32'h00000001, 32'h00000124, 32'h00000010, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_SRA,  32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
    add(0, OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    add(0, 6'h3F,   32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1);
    add(0, 6'h0C,   32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1);
    add(1, OP_MUL,  32'd15,       32'd17,       32'h000000FF, 1'b0, 1'b0, 1'b0, 9);
    add(1, OP_DIVU, 32'd200,      32'd7,        32'd28,       1'b0, 1'b0, 1'b0, 9);
    add(1, OP_REMU, 32'd200,      32'd7,        32'd4,        1'b0, 1'b0, 1'b0, 9);
    add(1, OP_DIVU, 32'd5,        32'd0,        32'h000000FF, 1'b0, 1'b1, 1'b0, 9);
    add(1, OP_ADD,  32'h7F,       32'h01,       32'h00000080, 1'b0, 1'b1, 1'b0, 1);
    add(1, OP_SRA,  32'h80,       32'h09,       32'h000000C0, 1'b0, 1'b0, 1'b0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset result",    result,              32'h0);
    check("reset flags",     {29'h0, zero, overflow, illegal}, 32'h0);
    check("reset out_valid", {31'h0, out_valid},  32'h0);
    check("reset result8",   {24'h0, result8},    32'h0);
    check("reset out_valid8", {31'h0, out_valid8}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", {30'h0, in_ready, in_ready8}, 32'h3);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag  = $sformatf("vec%0d", i);
      use8 = vecs[i].w8;
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      check({tag, " latency"},  32'(lat), 32'(vecs[i].lat));
      check({tag, " result"},   cur_result, vecs[i].res);
      check({tag, " zero"},     {31'h0, cur_zero}, {31'h0, vecs[i].z});
      check({tag, " overflow"}, {31'h0, cur_ovf},  {31'h0, vecs[i].o});
      check({tag, " illegal"},  {31'h0, cur_ill},  {31'h0, vecs[i].il});
      finish_op(tag);
    end
    use8 = 1'b0;

    // Backpressure: result and flags hold while out_ready stays low
    start_op(OP_XOR, 32'hF0F00F0F, 32'h0F0F0F0F);
    wait_done(lat);
    check("bp latency", 32'(lat), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || result !== 32'hFFFF0000 || zero !== 1'b0 ||
          overflow !== 1'b0 || illegal !== 1'b0) bad++;
    end
    check("bp hold cycles bad", 32'(bad), 32'd0);
    check("bp result", result, 32'hFFFF0000);
    finish_op("bp");

    // A second request during ITER must not be taken
    start_op(OP_MUL, 32'h0000FFFF, 32'h00010001);
    alufn = OP_ADD; a = 32'd2; b = 32'd3; in_valid = 1'b1;
    lat = 1; bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) bad++;
      if (lat == 20) in_valid = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("iter in_ready high cycles", 32'(bad), 32'd0);
    check("iter mul latency", 32'(lat), 32'd33);
    check("iter mul result", result, 32'hFFFFFFFF);
    finish_op("iter");

    // Reset in the middle of a MUL discards it
    start_op(OP_MUL, 32'h00001234, 32'h00005678);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst result", result, 32'h0);
    check("midrst flags", {29'h0, zero, overflow, illegal}, 32'h0);
    check("midrst out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst in_ready", {31'h0, in_ready}, 32'h1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("midrst no stale out_valid", 32'(bad), 32'd0);
    start_op(OP_ADD, 32'd2, 32'd3);
    wait_done(lat);
    check("post-reset add latency", 32'(lat), 32'd1);
    check("post-reset add result", result, 32'd5);
    finish_op("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational processor ALU.
- Keeps the 6-bit alufn opcode space (arith / logic / shift groups).
- Adds a valid/ready handshake on input and output.
- Adds iterative multi-cycle MUL and unsigned DIV/REM, signed SRA/SLT, and an illegal-opcode flag.
- Sits between the register-read stage and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0]; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode present
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount
- alufn  in  6  opcode
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU/REMU)
- illegal  out  1  opcode not in map

Behaviour:
- Opcode map:
  - 000000 ADD; 000001 SUB; 000010 MUL (low WIDTH bits of a*b); 000011 DIVU (a/b unsigned)
  - 000100 AND; 000101 OR; 000110 XOR; 000111 REMU (a%b unsigned)
  - 001000 SLL; 001001 SRL; 001010 SRA; 001011 SLT (signed compare, result 1 or 0)
  - All other codes are illegal.
- Handshake:
  - Accept occurs when in_valid && in_ready on a rising edge.
  - Result transfer occurs when out_valid && out_ready.
  - in_ready = (state == IDLE), combinational from state only. Inputs are ignored while in_ready = 0.
- FSM states IDLE, ITER, DONE:
  - IDLE, accept of single-cycle op or illegal opcode: register result/flags, go to DONE. out_valid rises the next cycle, so latency is 1.
  - IDLE, accept of MUL/DIVU/REMU: latch operands, load counter with WIDTH, go to ITER.
  - ITER: one shift-add (MUL) or restoring subtract-shift (DIVU/REMU) step per cycle. Counter decrements each cycle; at counter == 1 the final step is written to result and the FSM goes to DONE.
  - Multi-cycle latency is fixed at WIDTH+1 cycles from accept to out_valid, independent of operand values. No early termination.
  - DONE: out_valid = 1; result and flags held stable. On out_ready, go to IDLE. No new accept occurs in the same cycle, so throughput is at most one op per 2 cycles.
- Flags (all registered together with result):
  - zero = (result == 0) for every legal op.
  - overflow for ADD: operand signs equal and result sign differs.
  - overflow for SUB: operand signs differ and result sign differs from a.
  - overflow = 1 for DIVU/REMU when b == 0; otherwise 0.
  - Divide by zero: DIVU result = all ones; REMU result = a. The iteration still runs WIDTH cycles.
  - Illegal opcode: result = 0, zero = 0, overflow = 0, illegal = 1. illegal = 0 for all legal ops.
- Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- SRA replicates a[WIDTH-1].
- Reset (async, any state including mid-ITER): state = IDLE, out_valid = 0, result = 0, zero = 0, overflow = 0, illegal = 0, counter and iteration registers = 0. in_ready = 1 from the first cycle after rst_n deasserts. A partially computed op is discarded and never produces out_valid.
- out_ready while out_valid = 0 has no effect.
- Outputs are never X after reset.

Test Plan:
- ADD, WIDTH=32: a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept. SUB a=5, b=5 -> result 0, zero=1, overflow=0.
- MUL, WIDTH=32: a=0xFFFF, b=0x10001 -> result 0xFFFFFFFF after exactly 33 cycles. in_ready=0 throughout ITER; a second in_valid during ITER is not accepted.
- DIVU a=100, b=7 -> result 14; REMU same operands -> result 2. DIVU a=9, b=0 -> result 0xFFFFFFFF, overflow=1. REMU a=9, b=0 -> result 9, overflow=1.
- Shifts: SRA a=0x80000000, b=0x21 -> result 0xC0000000 (amount 1). SLT a=0xFFFFFFFF, b=1 -> result 1. SRL a=0x80000000, b=31 -> result 1.
- Backpressure: hold out_ready=0 for 5 cycles after XOR completes -> result, flags, out_valid stable, in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1. alufn=111111 -> illegal=1, result=0.
- Reset at cycle 10 of a MUL -> all outputs 0 and in_ready=1 after release. A following ADD 2+3 returns 5 with latency 1. Repeat with WIDTH=8: MUL 15*17 -> 0xFF after 9 cycles.
